// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Two-port arbiter in front of a single data memory. Port 0 is the core,
//   port 1 is the loader/DMA. One request is accepted at a time and walks
//   through IDLE -> ACCESS -> RESP, so a new request can be taken every third
//   cycle. Misaligned halfword/word accesses never reach the memory; they
//   return an error strobe instead.
//
// Configuration:
//   DMEM_ARB_FIXED_PRIO_EN  defined   -> port 0 always wins when both request.
//                           undefined -> round-robin, the port other than the
//                                        last-served one wins a tie.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   pN_valid / pN_ready        request handshake for port N (N = 0, 1)
//   pN_mode, pN_addr, pN_wdata access mode, byte address, store data
//   pN_rvalid                  one-cycle response strobe for port N
//   pN_rdata, pN_err           load result / misaligned flag with pN_rvalid
//   mem_mode, mem_addr,
//   mem_wdata                  request to data memory (driven in ACCESS only)
//   mem_rdata                  combinational read data from data memory
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic [2:0]            p0_mode,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_err,

    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic [2:0]            p1_mode,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_err,

    output logic [2:0]            mem_mode,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [2:0] MODE_LH  = 3'b001;
    localparam logic [2:0] MODE_LW  = 3'b010;
    localparam logic [2:0] MODE_LHU = 3'b100;
    localparam logic [2:0] MODE_SH  = 3'b110;
    localparam logic [2:0] MODE_SW  = 3'b111;

    // Halfword modes need addr[0]==0, word modes need addr[1:0]==0.
    function automatic logic isMisaligned(input logic [2:0] mode,
                                          input logic [1:0] lowAddr);
        case (mode)
            MODE_LH, MODE_LHU, MODE_SH: isMisaligned = lowAddr[0];
            MODE_LW, MODE_SW:           isMisaligned = |lowAddr;
            default:                    isMisaligned = 1'b0;
        endcase
    endfunction

    // Store modes are 101 (SB), 110 (SH) and 111 (SW).
    function automatic logic isStore(input logic [2:0] mode);
        isStore = mode[2] & (mode[1] | mode[0]);
    endfunction

    logic [1:0]            state_q, state_d;
    logic                  reqPort_q, reqPort_d;
    logic [2:0]            reqMode_q, reqMode_d;
    logic [ADDR_WIDTH-1:0] reqAddr_q, reqAddr_d;
    logic [DATA_WIDTH-1:0] reqWdata_q, reqWdata_d;
    logic                  reqMis_q, reqMis_d;
    logic [DATA_WIDTH-1:0] respData_q, respData_d;
    logic                  respErr_q, respErr_d;

    logic                  tieWinner;
    logic                  grantValid;
    logic                  grantPort;
    logic                  accept;
    logic [2:0]            selMode;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic [DATA_WIDTH-1:0] selWdata;
    logic                  driveMem;
    logic                  respActive;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign tieWinner = 1'b0;
`else
    // Last-served pointer; resets to port 1 so port 0 wins the first tie.
    logic lastPort_q, lastPort_d;

    assign tieWinner = ~lastPort_q;

    always_comb begin
        lastPort_d = lastPort_q;
        if (accept) begin
            lastPort_d = grantPort;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastPort_q <= 1'b1;
        end else begin
            lastPort_q <= lastPort_d;
        end
    end
`endif

    // A lone requester wins outright; a tie goes to tieWinner.
    always_comb begin
        grantValid = p0_valid | p1_valid;
        if (p0_valid && p1_valid) begin
            grantPort = tieWinner;
        end else begin
            grantPort = p1_valid;
        end
    end

    // rst_n is folded in so ready stays low while reset is held even
    // though the state register already sits in IDLE.
    assign accept   = rst_n && (state_q == IDLE) && grantValid;
    assign p0_ready = accept & ~grantPort;
    assign p1_ready = accept &  grantPort;

    assign selMode  = grantPort ? p1_mode  : p0_mode;
    assign selAddr  = grantPort ? p1_addr  : p0_addr;
    assign selWdata = grantPort ? p1_wdata : p0_wdata;

    always_comb begin
        state_d    = state_q;
        reqPort_d  = reqPort_q;
        reqMode_d  = reqMode_q;
        reqAddr_d  = reqAddr_q;
        reqWdata_d = reqWdata_q;
        reqMis_d   = reqMis_q;
        respData_d = respData_q;
        respErr_d  = respErr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = ACCESS;
                    reqPort_d  = grantPort;
                    reqMode_d  = selMode;
                    reqAddr_d  = selAddr;
                    reqWdata_d = selWdata;
                    reqMis_d   = isMisaligned(selMode, selAddr[1:0]);
                end
            end
            ACCESS: begin
                // Capture the memory result at the end of ACCESS; stores and
                // suppressed accesses return zero.
                state_d   = RESP;
                respErr_d = reqMis_q;
                if (!reqMis_q && !isStore(reqMode_q)) begin
                    respData_d = mem_rdata;
                end else begin
                    respData_d = '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            reqPort_q  <= 1'b0;
            reqMode_q  <= MODE_LW;
            reqAddr_q  <= '0;
            reqWdata_q <= '0;
            reqMis_q   <= 1'b0;
            respData_q <= '0;
            respErr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            reqPort_q  <= reqPort_d;
            reqMode_q  <= reqMode_d;
            reqAddr_q  <= reqAddr_d;
            reqWdata_q <= reqWdata_d;
            reqMis_q   <= reqMis_d;
            respData_q <= respData_d;
            respErr_q  <= respErr_d;
        end
    end

    // The memory sees a harmless LW of address 0 whenever no real access is
    // in flight, so a stray write can never happen.
    assign driveMem  = (state_q == ACCESS) && !reqMis_q;
    assign mem_mode  = driveMem ? reqMode_q  : MODE_LW;
    assign mem_addr  = driveMem ? reqAddr_q  : '0;
    assign mem_wdata = driveMem ? reqWdata_q : '0;

    assign respActive = (state_q == RESP);
    assign p0_rvalid  = respActive & ~reqPort_q;
    assign p1_rvalid  = respActive &  reqPort_q;
    assign p0_rdata   = p0_rvalid ? respData_q : '0;
    assign p1_rdata   = p1_rvalid ? respData_q : '0;
    assign p0_err     = p0_rvalid & respErr_q;
    assign p1_err     = p1_rvalid & respErr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter. Contains a byte-addressed data memory
// attached to the mem_* bus and a transaction-level reference model (cycle
// numbers for accept/access/response plus its own copy of memory contents).
// Directed scenarios are followed by randomized traffic from both ports.
// Honours DMEM_ARB_FIXED_PRIO_EN when defined.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd3;
    localparam logic [2:0] LHU = 3'd4;
    localparam logic [2:0] SB  = 3'd5;
    localparam logic [2:0] SH  = 3'd6;
    localparam logic [2:0] SW  = 3'd7;
    localparam int MEMB = 1024;

    logic        clk;
    logic        rst_n;
    logic        p0_valid, p1_valid;
    logic        p0_ready, p1_ready;
    logic [2:0]  p0_mode, p1_mode;
    logic [31:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_err, p1_err;
    logic [2:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_valid  (p0_valid),
        .p0_ready  (p0_ready),
        .p0_mode   (p0_mode),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p0_err    (p0_err),
        .p1_valid  (p1_valid),
        .p1_ready  (p1_ready),
        .p1_mode   (p1_mode),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .p1_err    (p1_err),
        .mem_mode  (mem_mode),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result of a load of the given mode out of four little-endian bytes.
    function automatic logic [31:0] loadValue(input logic [2:0] mode, input logic [31:0] w);
        case (mode)
            LB:      return {{24{w[7]}}, w[7:0]};
            LH:      return {{16{w[15]}}, w[15:0]};
            LW:      return w;
            LBU:     return {24'b0, w[7:0]};
            LHU:     return {16'b0, w[15:0]};
            default: return 32'b0;
        endcase
    endfunction

    function automatic int accessBytes(input logic [2:0] mode);
        if (mode == LH || mode == LHU || mode == SH) return 2;
        if (mode == LW || mode == SW) return 4;
        return 1;
    endfunction

    function automatic logic isStoreMode(input logic [2:0] mode);
        return mode >= SB;
    endfunction

    function automatic logic misaligned(input logic [2:0] mode, input logic [31:0] a);
        return (int'(a[1:0]) % accessBytes(mode)) != 0;
    endfunction

    function automatic logic [7:0] initByte(input int i);
        int t;
        t = i * 73 + (i >> 4) * 5 + 29;
        return t[7:0];
    endfunction

    // Data memory attached to the DUT: combinational read, write on rising
    // edge. Contents are loaded on the first clock and survive reset.
    logic [7:0] envMem [0:MEMB-1];
    logic       envLoaded;
    logic [9:0] envA;

    assign envA      = mem_addr[9:0];
    assign mem_rdata = loadValue(mem_mode, {envMem[envA + 10'd3], envMem[envA + 10'd2],
                                            envMem[envA + 10'd1], envMem[envA]});

    always @(posedge clk) begin
        if (envLoaded !== 1'b1) begin
            for (int i = 0; i < MEMB; i++) envMem[i] <= initByte(i);
            envLoaded <= 1'b1;
        end else begin
            case (mem_mode)
                SB: envMem[envA] <= mem_wdata[7:0];
                SH: begin
                    envMem[envA]         <= mem_wdata[7:0];
                    envMem[envA + 10'd1] <= mem_wdata[15:8];
                end
                SW: begin
                    envMem[envA]         <= mem_wdata[7:0];
                    envMem[envA + 10'd1] <= mem_wdata[15:8];
                    envMem[envA + 10'd2] <= mem_wdata[23:16];
                    envMem[envA + 10'd3] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    // Reference model state.
    logic [7:0]  refMem [0:MEMB-1];
    int          cyc;
    int          nextFree;
    int          accCyc;
    int          respCyc;
    int          respPort;
    int          lastServed;
    int          lastWinner;
    int          resetCyc;
    int          acceptCyc;
    logic [2:0]  accMode;
    logic [31:0] accAddr;
    logic [31:0] accWdata;
    logic        accMis;
    logic [31:0] respData;
    logic        respErr;
    logic        sawSH;
    int          servedQ [$];
    logic [31:0] obsRdata [2];
    logic        obsRvalid [2];
    logic        obsErr [2];

    int checks;
    int errors;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at cycle %0d", tag, observed, expected, cyc);
        end
    endtask

    function automatic logic [31:0] refWord(input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = refMem[(int'(a[9:0]) + k) % MEMB];
        return w;
    endfunction

    task automatic refStore(input logic [2:0] mode, input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < accessBytes(mode); k++) refMem[(int'(a[9:0]) + k) % MEMB] = d[8*k +: 8];
    endtask

    task automatic modelReset();
        nextFree   = cyc;
        resetCyc   = cyc;
        accCyc     = -10;
        respCyc    = -10;
        respPort   = 0;
        accMis     = 1'b0;
        lastServed = 1;
    endtask

    task automatic setPort(input int p, input logic v, input logic [2:0] m,
                           input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            p0_valid = v; p0_mode = m; p0_addr = a; p0_wdata = d;
        end else begin
            p1_valid = v; p1_mode = m; p1_addr = a; p1_wdata = d;
        end
    endtask

    task automatic setValid(input int p, input logic v);
        if (p == 0) p0_valid = v;
        else        p1_valid = v;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "P0Ready"},  p0_ready,  0);
        checkOutput({tag, "P1Ready"},  p1_ready,  0);
        checkOutput({tag, "P0Rvalid"}, p0_rvalid, 0);
        checkOutput({tag, "P1Rvalid"}, p1_rvalid, 0);
        checkOutput({tag, "P0Err"},    p0_err,    0);
        checkOutput({tag, "P1Err"},    p1_err,    0);
        checkOutput({tag, "P0Rdata"},  p0_rdata,  0);
        checkOutput({tag, "P1Rdata"},  p1_rdata,  0);
        checkOutput({tag, "MemMode"},  mem_mode,  LW);
        checkOutput({tag, "MemAddr"},  mem_addr,  0);
        checkOutput({tag, "MemWdata"}, mem_wdata, 0);
    endtask

    // One clock of the model: inputs are already driven; sample on the
    // falling edge, compare against the model, then advance to posedge+1.
    task automatic runCycle();
        int          winner;
        logic        inAcc;
        logic        resp0, resp1;
        logic [2:0]  m;
        logic [31:0] a, d;
        @(negedge clk);
        winner = -1;
        if (cyc >= nextFree) begin
            if (p0_valid && p1_valid) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                winner = 0;
`else
                winner = (lastServed == 0) ? 1 : 0;
`endif
            end else if (p0_valid) begin
                winner = 0;
            end else if (p1_valid) begin
                winner = 1;
            end
        end
        checkOutput("p0Ready", p0_ready, winner == 0);
        checkOutput("p1Ready", p1_ready, winner == 1);

        inAcc = (cyc == accCyc) && !accMis;
        checkOutput("memMode",  mem_mode,  inAcc ? accMode  : LW);
        checkOutput("memAddr",  mem_addr,  inAcc ? accAddr  : 32'b0);
        checkOutput("memWdata", mem_wdata, inAcc ? accWdata : 32'b0);
        if (mem_mode == SH) sawSH = 1'b1;

        resp0 = (cyc == respCyc) && (respPort == 0);
        resp1 = (cyc == respCyc) && (respPort == 1);
        checkOutput("p0Rvalid", p0_rvalid, resp0);
        checkOutput("p1Rvalid", p1_rvalid, resp1);
        checkOutput("p0Rdata",  p0_rdata,  resp0 ? respData : 32'b0);
        checkOutput("p1Rdata",  p1_rdata,  resp1 ? respData : 32'b0);
        checkOutput("p0Err",    p0_err,    resp0 && respErr);
        checkOutput("p1Err",    p1_err,    resp1 && respErr);
        obsRdata[0] = p0_rdata;  obsRdata[1] = p1_rdata;
        obsRvalid[0] = p0_rvalid; obsRvalid[1] = p1_rvalid;
        obsErr[0] = p0_err;      obsErr[1] = p1_err;

        if (inAcc && isStoreMode(accMode)) refStore(accMode, accAddr, accWdata);

        lastWinner = winner;
        if (winner >= 0) begin
            m = (winner == 0) ? p0_mode  : p1_mode;
            a = (winner == 0) ? p0_addr  : p1_addr;
            d = (winner == 0) ? p0_wdata : p1_wdata;
            accMode    = m;
            accAddr    = a;
            accWdata   = d;
            accMis     = misaligned(m, a);
            respPort   = winner;
            accCyc     = cyc + 1;
            respCyc    = cyc + 2;
            nextFree   = cyc + 3;
            respErr    = accMis;
            respData   = (accMis || isStoreMode(m)) ? 32'b0 : loadValue(m, refWord(a));
            lastServed = winner;
            acceptCyc  = cyc;
            servedQ.push_back(winner);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Hold one request until accepted, then run through ACCESS and RESP.
    task automatic issueReq(input int port, input logic [2:0] m,
                            input logic [31:0] a, input logic [31:0] d);
        logic got;
        got = 1'b0;
        setPort(port, 1'b1, m, a, d);
        for (int i = 0; i < 8 && !got; i++) begin
            runCycle();
            if (lastWinner == port) got = 1'b1;
        end
        checkOutput("acceptTimeout", got, 1);
        setValid(port, 1'b0);
        runCycle();
        runCycle();
    endtask

    task automatic applyStimulus(input int nCycles);
        bit pend [2];
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int c = 0; c < nCycles; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pend[p] = 1'b1;
                        setPort(p, 1'b1, 3'($urandom_range(0, 7)),
                                32'h100 + 32'($urandom_range(0, 63)), $urandom());
                    end else begin
                        setValid(p, 1'b0);
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    pend[p] = 1'b0;
                    setValid(p, 1'b0);
                end
            end
            runCycle();
            if (lastWinner >= 0) pend[lastWinner] = 1'b0;
        end
        setValid(0, 1'b0);
        setValid(1, 1'b0);
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog simulation did not finish observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] expected300;
        logic        got;
        checks = 0;
        errors = 0;
        cyc    = 0;
        sawSH  = 1'b0;
        for (int i = 0; i < MEMB; i++) refMem[i] = initByte(i);

        // Reset held with both ports requesting: everything must stay quiet.
        rst_n = 1'b0;
        setPort(0, 1'b1, SW, 32'h104, 32'h11111111);
        setPort(1, 1'b1, SW, 32'h108, 32'h22222222);
        repeat (3) begin
            @(negedge clk);
            checkResetOutputs("reset");
        end
        @(posedge clk);
        #1;
        setValid(0, 1'b0);
        setValid(1, 1'b0);
        rst_n = 1'b1;
        modelReset();

        // Store then load the same word from the core port.
        issueReq(0, SW, 32'h100, 32'hDEADBEEF);
        checkOutput("firstAcceptCycle", acceptCyc, resetCyc);
        checkOutput("swRvalid", obsRvalid[0], 1);
        checkOutput("swRdata",  obsRdata[0], 32'h0);
        issueReq(0, LW, 32'h100, 32'h0);
        checkOutput("lwRvalidAt2", obsRvalid[0], 1);
        checkOutput("lwRdata", obsRdata[0], 32'hDEADBEEF);
        checkOutput("lwErr",   obsErr[0], 0);

        // Misaligned halfword store from the loader port is suppressed.
        sawSH = 1'b0;
        issueReq(1, SH, 32'h101, 32'h00001234);
        checkOutput("misErr",   obsErr[1], 1);
        checkOutput("misRdata", obsRdata[1], 32'h0);
        checkOutput("misNoSH",  sawSH, 0);
        issueReq(1, LW, 32'h100, 32'h0);
        checkOutput("misKeepLw", obsRdata[1], 32'hDEADBEEF);

        // Byte store with signed and unsigned reload.
        issueReq(0, SB, 32'h200, 32'h000000F0);
        issueReq(0, LB, 32'h200, 32'h0);
        checkOutput("lbSigned", obsRdata[0], 32'hFFFFFFF0);
        issueReq(0, LBU, 32'h200, 32'h0);
        checkOutput("lbuZero", obsRdata[0], 32'h000000F0);

        // Reset in the middle of a word store: no response, no write.
        expected300 = refWord(32'h300);
        got = 1'b0;
        setPort(0, 1'b1, SW, 32'h300, 32'hCAFEF00D);
        for (int i = 0; i < 8 && !got; i++) begin
            runCycle();
            if (lastWinner == 0) got = 1'b1;
        end
        checkOutput("rstAcceptTimeout", got, 1);
        setValid(0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rstMidAccess");
        repeat (2) begin
            @(negedge clk);
            checkResetOutputs("rstHeld");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();

        // Both ports loading every cycle straight out of reset.
        servedQ.delete();
        setPort(0, 1'b1, LW, 32'h100, 32'h0);
        setPort(1, 1'b1, LW, 32'h104, 32'h0);
        repeat (12) runCycle();
        setValid(0, 1'b0);
        setValid(1, 1'b0);
        checkOutput("tieGrantCount", servedQ.size(), 4);
        for (int i = 0; i < servedQ.size(); i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            checkOutput("tieGrantFixed", servedQ[i], 0);
`else
            checkOutput("tieGrantAlt", servedQ[i], i % 2);
`endif
        end
        runCycle();
        runCycle();

        issueReq(1, LW, 32'h300, 32'h0);
        checkOutput("rstRetained", obsRdata[1], expected300);

        applyStimulus(400);
        repeat (4) runCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
